// File: rtl/life_array_reader.sv
// Read-side master for the 8x8 life array: snapshots each 4x4 tile, streams its
// 64 cells as (x,y) beats over valid/ready, then optionally pulses a generation step.
module life_array_reader #(
  parameter bit AUTO_STEP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] valo,
  input  logic [15:0] valo_prev,
  output logic [1:0]  valo_selector,
  output logic        cell_valid,
  input  logic        cell_ready,
  output logic [2:0]  cell_x,
  output logic [2:0]  cell_y,
  output logic        cell_alive,
  output logic        cell_prev,
  output logic        cell_changed,
  output logic        cell_last,
  output logic        busy,
  output logic        done,
  output logic        step
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  tile_q, tile_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  beat_q, beat_d;
  logic [15:0] alive_q, alive_d;
  logic [15:0] prev_q, prev_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        step_q, step_d;
  logic        xfer;

  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    sel_d   = sel_q;
    beat_d  = beat_q;
    alive_d = alive_q;
    prev_d  = prev_q;
    xfer    = valid_q & cell_ready;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = '0;
          tile_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        alive_d = valo;
        prev_d  = valo_prev;
        beat_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (beat_q != 4'd15) begin
            beat_d = beat_q + 4'd1;
          end else if (tile_q != 2'd3) begin
            tile_d  = tile_q + 2'd1;
            sel_d   = tile_q + 2'd1;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state's decode.
    valid_d = (state_d == SEND);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    step_d  = (state_d == DONE) && AUTO_STEP;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      tile_q  <= '0;
      sel_q   <= '0;
      beat_q  <= '0;
      alive_q <= '0;
      prev_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      sel_q   <= sel_d;
      beat_q  <= beat_d;
      alive_q <= alive_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      step_q  <= step_d;
    end
  end

  // Tile bit 1 selects the column half, tile bit 0 the row half.
  assign valo_selector = sel_q;
  assign cell_valid    = valid_q;
  assign cell_x        = {tile_q[1], beat_q[3:2]};
  assign cell_y        = {tile_q[0], beat_q[1:0]};
  assign cell_alive    = alive_q[beat_q];
  assign cell_prev     = prev_q[beat_q];
  assign cell_changed  = alive_q[beat_q] ^ prev_q[beat_q];
  assign cell_last     = valid_q && (tile_q == 2'd3) && (beat_q == 4'd15);
  assign busy          = busy_q;
  assign done          = done_q;
  assign step          = step_q;

endmodule

// File: tb/tb_life_array_reader.sv
// Scoreboard bench for life_array_reader: stimulus pushes expected beats, a negedge
// monitor pops and compares each transferred beat and tracks pulse timing.
module tb_life_array_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start0, cell_ready, ready0;
  logic [15:0] valo, valo_prev, valo0, valo_prev0;
  logic [1:0]  valo_selector, sel0;
  logic        cell_valid, cell_alive, cell_prev, cell_changed, cell_last, busy, done, step;
  logic [2:0]  cell_x, cell_y, x0, y0;
  logic        valid0, alive0, prev0, changed0, last0, busy0, done0, step0;

  logic [15:0] arr_cur  [4];
  logic [15:0] arr_prev [4];
  assign valo      = arr_cur[valo_selector];
  assign valo_prev = arr_prev[valo_selector];

  life_array_reader #(.AUTO_STEP(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .valo(valo), .valo_prev(valo_prev),
    .valo_selector(valo_selector), .cell_valid(cell_valid), .cell_ready(cell_ready),
    .cell_x(cell_x), .cell_y(cell_y), .cell_alive(cell_alive), .cell_prev(cell_prev),
    .cell_changed(cell_changed), .cell_last(cell_last), .busy(busy), .done(done), .step(step)
  );

  life_array_reader #(.AUTO_STEP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .valo(valo0), .valo_prev(valo_prev0),
    .valo_selector(sel0), .cell_valid(valid0), .cell_ready(ready0),
    .cell_x(x0), .cell_y(y0), .cell_alive(alive0), .cell_prev(prev0),
    .cell_changed(changed0), .cell_last(last0), .busy(busy0), .done(done0), .step(step0)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [11:0] exp_q [$];
  int          done_cyc_q [$];
  int beats, nalive, last_cnt, first_valid_cyc, last_cyc, done_cnt, step_cnt, step_cyc;
  int busy_fall_cyc, dup_cnt, stall_cnt;
  int beats0, alive_cnt0, chg_cnt0, prev_cnt0, done0_cnt, step0_cnt, done0_cyc;
  logic [63:0] seen_map, alive_map, chg_map;
  logic [15:0] chg_acc [4];
  logic        stall_pending, busy_prev;
  logic [11:0] snap;

  task automatic clear_stats();
    beats = 0; nalive = 0; last_cnt = 0; first_valid_cyc = -1; last_cyc = -1;
    done_cnt = 0; step_cnt = 0; step_cyc = -1; busy_fall_cyc = -1; dup_cnt = 0;
    stall_cnt = 0; seen_map = '0; alive_map = '0; chg_map = '0;
    for (int t = 0; t < 4; t++) chg_acc[t] = '0;
    done_cyc_q.delete();
  endtask

  task automatic push_frame();
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 16; k++) begin
        int x, y;
        logic a, p;
        x = (t / 2) * 4 + k / 4;
        y = (t % 2) * 4 + k % 4;
        a = arr_cur[t][k];
        p = arr_prev[t][k];
        exp_q.push_back({3'(x), 3'(y), a, p, a ^ p, (t == 3 && k == 15), 2'(t)});
      end
    end
  endtask

  // Monitor: compares every transferred beat and checks hold behaviour across stalls.
  always @(negedge clk) begin
    logic [11:0] act;
    logic [11:0] e;
    int idx;
    act = {cell_x, cell_y, cell_alive, cell_prev, cell_changed, cell_last, valo_selector};
    if (!reset) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        chk("stall_valid", {63'd0, cell_valid}, 64'd1);
        chk("stall_hold", {52'd0, act}, {52'd0, snap});
        stall_pending = 1'b0;
      end
      if (cell_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (cell_valid && cell_ready) begin
        chk("beat_expected", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat", {52'd0, act}, {52'd0, e});
        end
        idx = int'(cell_x) * 8 + int'(cell_y);
        if (seen_map[idx]) dup_cnt++;
        seen_map[idx] = 1'b1;
        if (cell_alive) begin nalive++; alive_map[idx] = 1'b1; end
        if (cell_changed) chg_map[idx] = 1'b1;
        chg_acc[{cell_x[2], cell_y[2]}][{cell_x[1:0], cell_y[1:0]}] = cell_changed;
        beats++;
        if (cell_last) begin last_cnt++; last_cyc = cyc; end
      end else if (cell_valid) begin
        stall_pending = 1'b1;
        snap = act;
        stall_cnt++;
      end
      if (done) begin done_cnt++; done_cyc_q.push_back(cyc); end
      if (step) begin step_cnt++; step_cyc = cyc; end
      if (busy_prev && !busy) busy_fall_cyc = cyc;
      if (valid0 && ready0) begin
        beats0++;
        if (alive0) alive_cnt0++;
        if (changed0) chg_cnt0++;
        if (prev0) prev_cnt0++;
        if (last0) begin
          chk("auto0_last_x", {61'd0, x0}, 64'd7);
          chk("auto0_last_y", {61'd0, y0}, 64'd7);
        end
      end
      if (done0) begin done0_cnt++; done0_cyc = cyc; end
    end
    if (step0) step0_cnt++;
    busy_prev = busy;
  end

  task automatic start_pulse(output int t0);
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #2;
      if (done_cnt >= target) break;
    end
    chk("done_count", done_cnt, target);
  endtask

  initial begin
    int t0;
    reset = 1'b0; start = 1'b0; start0 = 1'b0; cell_ready = 1'b1; ready0 = 1'b1;
    valo0 = 16'hFFFF; valo_prev0 = 16'h0000;
    beats0 = 0; alive_cnt0 = 0; chg_cnt0 = 0; prev_cnt0 = 0;
    done0_cnt = 0; step0_cnt = 0; done0_cyc = -1;
    stall_pending = 1'b0; busy_prev = 1'b0; snap = '0;
    for (int t = 0; t < 4; t++) begin arr_cur[t] = '0; arr_prev[t] = '0; end
    clear_stats();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, cell_valid}, 64'd0);
    chk("rst_sel", {62'd0, valo_selector}, 64'd0);
    chk("rst_done", {62'd0, done, step}, 64'd0);
    chk("rst_last", {63'd0, cell_last}, 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Single alive bit per tile at bit index t.
    for (int t = 0; t < 4; t++) begin arr_cur[t] = 16'h0001 << t; arr_prev[t] = '0; end
    clear_stats();
    push_frame();
    start_pulse(t0);
    wait_done(1, 200);
    repeat (2) @(posedge clk);
    #1;
    chk("f1_first_valid", first_valid_cyc, t0 + 1);
    chk("f1_last_xfer", last_cyc, t0 + 67);
    chk("f1_done_cyc", done_cyc_q[0], t0 + 68);
    chk("f1_step_cyc", step_cyc, t0 + 68);
    chk("f1_busy_fall", busy_fall_cyc, t0 + 69);
    chk("f1_beats", beats, 64);
    chk("f1_alive_cnt", nalive, 4);
    chk("f1_alive_map", alive_map, 64'h0000_0084_0000_0021);
    chk("f1_changed_map", chg_map, 64'h0000_0084_0000_0021);
    chk("f1_last_cnt", last_cnt, 1);
    chk("f1_step_cnt", step_cnt, 1);
    chk("f1_queue_empty", exp_q.size(), 0);

    // All-ones sweep: every coordinate exactly once.
    for (int t = 0; t < 4; t++) begin arr_cur[t] = 16'hFFFF; arr_prev[t] = '0; end
    clear_stats();
    push_frame();
    start_pulse(t0);
    wait_done(1, 200);
    chk("sweep_beats", beats, 64);
    chk("sweep_dups", dup_cnt, 0);
    chk("sweep_seen", seen_map, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sweep_alive", alive_map, 64'hFFFF_FFFF_FFFF_FFFF);

    // Random backpressure.
    for (int t = 0; t < 4; t++) begin arr_cur[t] = 16'hA5A5; arr_prev[t] = 16'hFFFF; end
    clear_stats();
    push_frame();
    start_pulse(t0);
    for (int i = 0; i < 600 && done_cnt < 1; i++) begin
      @(posedge clk); #1;
      cell_ready = ($urandom_range(0, 1) == 1);
    end
    cell_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rnd_done", done_cnt, 1);
    chk("rnd_beats", beats, 64);
    chk("rnd_stalls_seen", {63'd0, stall_cnt > 0}, 64'd1);
    for (int t = 0; t < 4; t++) chk("rnd_changed_tile", {48'd0, chg_acc[t]}, 64'h5A5A);
    chk("rnd_queue_empty", exp_q.size(), 0);

    // start held high: three back-to-back frames.
    for (int t = 0; t < 4; t++) begin arr_cur[t] = 16'h0F0F ^ 16'(t); arr_prev[t] = 16'h00FF; end
    clear_stats();
    push_frame(); push_frame(); push_frame();
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc + 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (done_cnt >= 3) break;
    end
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("b2b_done", done_cnt, 3);
    chk("b2b_step", step_cnt, 3);
    chk("b2b_beats", beats, 192);
    chk("b2b_first_done", done_cyc_q[0], t0 + 68);
    chk("b2b_gap1", done_cyc_q[1] - done_cyc_q[0], 70);
    chk("b2b_gap2", done_cyc_q[2] - done_cyc_q[1], 70);
    chk("b2b_idle_after", {63'd0, busy}, 64'd0);
    chk("b2b_queue_empty", exp_q.size(), 0);

    // Reset asserted at tile 2, beat 7 aborts the frame.
    for (int t = 0; t < 4; t++) begin arr_cur[t] = 16'hFFFF; arr_prev[t] = '0; end
    clear_stats();
    push_frame();
    start_pulse(t0);
    repeat (42) @(posedge clk);
    #1;
    chk("abort_pos_x", {61'd0, cell_x}, 64'd5);
    chk("abort_pos_y", {61'd0, cell_y}, 64'd3);
    chk("abort_pos_sel", {62'd0, valo_selector}, 64'd2);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_valid", {63'd0, cell_valid}, 64'd0);
    chk("abort_sel", {62'd0, valo_selector}, 64'd0);
    chk("abort_beats", beats, 39);
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_step", step_cnt, 0);
    chk("abort_still_idle", {63'd0, busy}, 64'd0);

    // AUTO_STEP=0 instance.
    @(posedge clk); #1;
    start0 = 1'b1;
    t0 = cyc + 1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (done0_cnt >= 1) break;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("auto0_done", done0_cnt, 1);
    chk("auto0_done_cyc", done0_cyc, t0 + 68);
    chk("auto0_step", step0_cnt, 0);
    chk("auto0_beats", beats0, 64);
    chk("auto0_alive", alive_cnt0, 64);
    chk("auto0_changed", chg_cnt0, 64);
    chk("auto0_prev", prev_cnt0, 0);
    chk("auto0_sel_hold", {62'd0, sel0}, 64'd3);
    chk("auto0_busy", {63'd0, busy0}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
